pwm_fade_ctrl: RTL and testbench

Duty-cycle sequencer that sits directly upstream of the 8-bit PWM generator and drives its dutyCycle input.
- Single mode: ramps the duty value from its current level to a target at a programmable step size and step rate.
- Breathe mode: ramps continuously between 0 and the target, with a programmable hold time at each end.
- Command handshake: start/stop in, busy/done out.

---
 rtl/pwm_fade_ctrl_pkg.sv | 29 ++
 rtl/pwm_fade_ctrl_tick.sv | 34 +++
 rtl/pwm_fade_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_fade_ctrl_pkg.sv
// Shared definitions for the PWM duty-cycle fade sequencer.
// Holds the state encoding, the mode constants, the duty width and a step helper.
package pwm_fade_ctrl_pkg;

    localparam int DUTY_W = 8;

    localparam logic MODE_SINGLE  = 1'b0;
    localparam logic MODE_BREATHE = 1'b1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_UP       = 3'd1;
    localparam logic [2:0] ST_DOWN     = 3'd2;
    localparam logic [2:0] ST_HOLD_TOP = 3'd3;
    localparam logic [2:0] ST_HOLD_BOT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_UP       = ST_UP,
        S_DOWN     = ST_DOWN,
        S_HOLD_TOP = ST_HOLD_TOP,
        S_HOLD_BOT = ST_HOLD_BOT
    } state_t;

    // A step of zero would stall the ramp forever, so it runs as one.
    function automatic logic [DUTY_W-1:0] fix_step(input logic [DUTY_W-1:0] s);
        return (s == '0) ? DUTY_W'(1) : s;
    endfunction

endpackage

// File: rtl/pwm_fade_ctrl_tick.sv
// fade_tick_gen: DIV-cycle prescaler producing a one-cycle step strobe.
// Ports: clk, rst (sync, high), i_run (count enable), i_clr (sync clear), o_tick.
module fade_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_clr,
    output logic o_tick
);

    if (DIV < 2) begin : g_bad_div
        $error("fade_tick_gen: DIV must be >= 2");
    end

    localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = i_run && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: duty sequencer feeding the 8-bit PWM stage (single ramp / breathe).
// Ports: clk, rst, enable, start, stop, mode, target, stepSize, holdTicks -> dutyCycle, busy, done.
module pwm_fade_ctrl
    import pwm_fade_ctrl_pkg::*;
#(
    parameter int CLK_FREQ = 12000000,
    parameter int STEP_HZ  = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic [DUTY_W-1:0] target,
    input  logic [DUTY_W-1:0] stepSize,
    input  logic [DUTY_W-1:0] holdTicks,
    output logic [DUTY_W-1:0] dutyCycle,
    output logic              busy,
    output logic              done
);

    localparam int DIV = CLK_FREQ / STEP_HZ;

    state_t            r_state, w_state;
    logic [DUTY_W-1:0] r_duty,  w_duty;
    logic [DUTY_W-1:0] r_tgt,   w_tgt;
    logic [DUTY_W-1:0] r_step,  w_step;
    logic [DUTY_W-1:0] r_hold,  w_hold;
    logic [DUTY_W-1:0] r_hcnt,  w_hcnt;
    logic              r_mode,  w_mode;
    logic              r_done,  w_done;

    logic              w_tick;
    logic              w_run;
    logic              w_accept;
    logic [DUTY_W:0]   w_sum;
    logic [DUTY_W:0]   w_dif;
    logic [DUTY_W-1:0] w_floor;
    logic              w_up_hit;
    logic              w_dn_hit;
    logic              w_hold_end;

    assign w_run    = enable && (r_state != S_IDLE);
    assign w_accept = enable && (r_state == S_IDLE) && start && !stop;

    fade_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_run  (w_run),
        .i_clr  (w_accept),
        .o_tick (w_tick)
    );

    // 9-bit arithmetic so the ramp saturates instead of wrapping.
    assign w_sum    = {1'b0, r_duty} + {1'b0, r_step};
    assign w_dif    = {1'b0, r_duty} - {1'b0, r_step};
    assign w_floor  = (r_mode == MODE_BREATHE) ? '0 : r_tgt;
    assign w_up_hit = w_sum >= {1'b0, r_tgt};
    assign w_dn_hit = w_dif[DUTY_W] || (w_dif[DUTY_W-1:0] <= w_floor);

    // A dwell ends on the tick that brings the count up to holdTicks.
    assign w_hold_end = ({1'b0, r_hcnt} + 9'd1) >= {1'b0, r_hold};

    always_comb begin
        w_state = r_state;
        w_duty  = r_duty;
        w_tgt   = r_tgt;
        w_step  = r_step;
        w_hold  = r_hold;
        w_hcnt  = r_hcnt;
        w_mode  = r_mode;
        w_done  = 1'b0;

        if (stop) begin
            w_state = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_mode = mode;
                        w_tgt  = target;
                        w_step = fix_step(stepSize);
                        w_hold = holdTicks;
                        w_hcnt = '0;
                        if (target > r_duty) begin
                            w_state = S_UP;
                        end else if (target < r_duty) begin
                            w_state = S_DOWN;
                        end else if (mode == MODE_BREATHE) begin
                            w_state = S_HOLD_TOP;
                        end else begin
                            w_done = 1'b1;
                        end
                    end
                end
                S_UP: begin
                    if (w_tick) begin
                        if (w_up_hit) begin
                            w_duty = r_tgt;
                            w_hcnt = '0;
                            if (r_mode == MODE_SINGLE) begin
                                w_state = S_IDLE;
                                w_done  = 1'b1;
                            end else if (r_hold == '0) begin
                                w_state = S_DOWN;
                            end else begin
                                w_state = S_HOLD_TOP;
                            end
                        end else begin
                            w_duty = w_sum[DUTY_W-1:0];
                        end
                    end
                end
                S_DOWN: begin
                    if (w_tick) begin
                        if (w_dn_hit) begin
                            w_duty = w_floor;
                            w_hcnt = '0;
                            if (r_mode == MODE_SINGLE) begin
                                w_state = S_IDLE;
                                w_done  = 1'b1;
                            end else if (r_hold == '0) begin
                                w_state = S_UP;
                            end else begin
                                w_state = S_HOLD_BOT;
                            end
                        end else begin
                            w_duty = w_dif[DUTY_W-1:0];
                        end
                    end
                end
                S_HOLD_TOP: begin
                    if (w_tick) begin
                        if (w_hold_end) begin
                            w_hcnt = '0;
                            // A zero top means there is nothing to ramp down.
                            w_state = (r_duty == '0) ? S_HOLD_BOT : S_DOWN;
                        end else begin
                            w_hcnt = r_hcnt + 1'b1;
                        end
                    end
                end
                S_HOLD_BOT: begin
                    if (w_tick) begin
                        if (w_hold_end) begin
                            w_hcnt = '0;
                            w_state = (r_tgt == '0) ? S_HOLD_TOP : S_UP;
                        end else begin
                            w_hcnt = r_hcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_duty  <= '0;
            r_tgt   <= '0;
            r_step  <= DUTY_W'(1);
            r_hold  <= '0;
            r_hcnt  <= '0;
            r_mode  <= MODE_SINGLE;
            r_done  <= 1'b0;
        end else if (enable) begin
            r_state <= w_state;
            r_duty  <= w_duty;
            r_tgt   <= w_tgt;
            r_step  <= w_step;
            r_hold  <= w_hold;
            r_hcnt  <= w_hcnt;
            r_mode  <= w_mode;
            r_done  <= w_done;
        end
    end

    assign dutyCycle = r_duty;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Testbench for pwm_fade_ctrl with DIV=10: vector table, directed corners, random vs model.
// Drives on the falling edge and samples outputs on the falling edge.
module tb_pwm_fade_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] target = '0;
    logic [7:0] stepSize = '0;
    logic [7:0] holdTicks = '0;
    logic [7:0] dutyCycle;
    logic       busy;
    logic       done;

    pwm_fade_ctrl #(
        .CLK_FREQ (1000),
        .STEP_HZ  (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .target    (target),
        .stepSize  (stepSize),
        .holdTicks (holdTicks),
        .dutyCycle (dutyCycle),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cur = 0;

    typedef struct {
        int init;
        int tgt;
        int step;
        int ticks;
    } vec_t;

    typedef int seq_t [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cur = 0;
    endtask

    // Single-mode ramp from the bench-tracked level 'cur' to tgt.
    task automatic run_ramp(input int tgt, input int step, input int ticks, input string nm);
        int e;
        int s;
        int n;
        bit got;
        int up;
        mode = 1'b0;
        target = 8'(tgt);
        stepSize = 8'(step);
        holdTicks = 8'($urandom_range(0, 5));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        target = 8'($urandom);
        stepSize = 8'($urandom);
        if (tgt == cur) begin
            chk({nm, " eq done"}, 32'(done), 1);
            chk({nm, " eq busy"}, 32'(busy), 0);
            @(negedge clk);
            chk({nm, " eq done drop"}, 32'(done), 0);
            return;
        end
        chk({nm, " busy"}, 32'(busy), 1);
        e = cur;
        s = (step == 0) ? 1 : step;
        up = (tgt > cur);
        n = 0;
        got = 0;
        while (n < 3000 && !got) begin
            @(negedge clk);
            n++;
            if (n % 10 == 0) begin
                if (up != 0) e = (e + s > tgt) ? tgt : e + s;
                else e = (e - s < tgt) ? tgt : e - s;
                chk($sformatf("%s duty@%0d", nm, n), 32'(dutyCycle), 32'(e));
            end
            if (done) got = 1;
        end
        chk({nm, " done time"}, 32'(n), 32'(10 * ticks));
        chk({nm, " busy at done"}, 32'(busy), 0);
        chk({nm, " final"}, 32'(dutyCycle), 32'(tgt));
        @(negedge clk);
        chk({nm, " done pulse"}, 32'(done), 0);
        cur = tgt;
    endtask

    task automatic run_breathe(input int tgt, input int st, input int hd,
                               input seq_t exp, input int n, input string nm);
        bit saw_done;
        bit saw_idle;
        do_reset();
        mode = 1'b1;
        target = 8'(tgt);
        stepSize = 8'(st);
        holdTicks = 8'(hd);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        target = 8'd99;
        saw_done = 0;
        saw_idle = 0;
        for (int t = 0; t < n; t++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (done) saw_done = 1;
                if (!busy) saw_idle = 1;
            end
            chk($sformatf("%s tick%0d", nm, t + 1), 32'(dutyCycle), 32'(exp[t]));
        end
        chk({nm, " no done"}, 32'(saw_done), 0);
        chk({nm, " stays busy"}, 32'(saw_idle), 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk({nm, " stop"}, 32'(busy), 0);
    endtask

    // Reference model: phases 0 idle, 1 rise, 2 fall, 3 top dwell, 4 bottom dwell.
    int md, ph, mcnt, mh, mmode, mtgt, mstep, mhold, mdone;

    task automatic model_step();
        int nd;
        int fl;
        bit tk;
        nd = 0;
        if (rst) begin
            md = 0; ph = 0; mcnt = 0; mh = 0; mdone = 0;
        end else if (enable) begin
            if (stop) begin
                ph = 0;
            end else if (ph == 0) begin
                if (start) begin
                    mmode = int'(mode);
                    mtgt = int'(target);
                    mstep = (stepSize == 0) ? 1 : int'(stepSize);
                    mhold = int'(holdTicks);
                    mcnt = 0;
                    mh = 0;
                    if (mtgt > md) ph = 1;
                    else if (mtgt < md) ph = 2;
                    else if (mmode != 0) ph = 3;
                    else nd = 1;
                end
            end else begin
                tk = (mcnt == 9);
                mcnt = (mcnt + 1) % 10;
                if (tk) begin
                    fl = (mmode != 0) ? 0 : mtgt;
                    if (ph == 1) begin
                        md = (md + mstep > mtgt) ? mtgt : md + mstep;
                        if (md == mtgt) begin
                            mh = 0;
                            if (mmode == 0) begin ph = 0; nd = 1; end
                            else ph = (mhold == 0) ? 2 : 3;
                        end
                    end else if (ph == 2) begin
                        md = (md - mstep < fl) ? fl : md - mstep;
                        if (md == fl) begin
                            mh = 0;
                            if (mmode == 0) begin ph = 0; nd = 1; end
                            else ph = (mhold == 0) ? 1 : 4;
                        end
                    end else begin
                        mh++;
                        if (mh >= mhold) begin
                            mh = 0;
                            if (ph == 3) ph = (md == 0) ? 4 : 2;
                            else ph = (mtgt == 0) ? 3 : 1;
                        end
                    end
                end
            end
            mdone = nd;
        end
    endtask

    initial begin
        vec_t vecs [7];
        seq_t s1;
        seq_t s0;
        bit flag;

        vecs[0] = '{0, 50, 16, 4};
        vecs[1] = '{250, 255, 16, 1};
        vecs[2] = '{5, 0, 16, 1};
        vecs[3] = '{10, 13, 0, 3};
        vecs[4] = '{200, 100, 30, 4};
        vecs[5] = '{0, 255, 255, 1};
        vecs[6] = '{50, 50, 7, 0};
        s1 = '{2, 4, 4, 2, 0, 0, 2, 4, 4, 2, 0, 0};
        s0 = '{2, 4, 2, 0, 2, 4, 2, 0, 0, 0, 0, 0};

        // Reset held with start asserted.
        rst = 1'b1;
        start = 1'b1;
        target = 8'd100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst duty", 32'(dutyCycle), 0);
            chk("rst busy", 32'(busy), 0);
            chk("rst done", 32'(done), 0);
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("post rst duty", 32'(dutyCycle), 0);
        chk("post rst busy", 32'(busy), 0);
        chk("post rst done", 32'(done), 0);

        // Table of single ramps.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            if (vecs[i].init != 0)
                run_ramp(vecs[i].init, 255, 1, $sformatf("row%0d init", i));
            run_ramp(vecs[i].tgt, vecs[i].step, vecs[i].ticks, $sformatf("row%0d", i));
        end

        // Breathe with and without dwell.
        run_breathe(4, 2, 1, s1, 12, "breathe h1");
        run_breathe(4, 2, 0, s0, 8, "breathe h0");

        // Abort mid-ramp, then start+stop together from IDLE.
        do_reset();
        mode = 1'b0;
        target = 8'd100;
        stepSize = 8'd16;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort pre", 32'(dutyCycle), 32);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("abort busy", 32'(busy), 0);
        chk("abort duty", 32'(dutyCycle), 32);
        chk("abort done", 32'(done), 0);
        flag = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) flag = 1;
        end
        chk("abort quiet", 32'(flag), 0);
        target = 8'd200;
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        chk("start+stop busy", 32'(busy), 0);
        repeat (15) @(negedge clk);
        chk("start+stop duty", 32'(dutyCycle), 32);

        // Freeze for 25 cycles mid-ramp.
        do_reset();
        target = 8'd100;
        stepSize = 8'd16;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk("frz pre", 32'(dutyCycle), 16);
        enable = 1'b0;
        repeat (25) @(negedge clk);
        chk("frz hold", 32'(dutyCycle), 16);
        chk("frz busy", 32'(busy), 1);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        chk("frz late", 32'(dutyCycle), 16);
        @(negedge clk);
        chk("frz tick", 32'(dutyCycle), 32);
        repeat (10) @(negedge clk);
        chk("frz next", 32'(dutyCycle), 48);

        // Reset in the middle of a breathe cycle.
        do_reset();
        mode = 1'b1;
        target = 8'd200;
        stepSize = 8'd10;
        holdTicks = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (35) @(negedge clk);
        chk("brst pre", 32'(dutyCycle), 30);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("brst duty", 32'(dutyCycle), 0);
        chk("brst busy", 32'(busy), 0);
        @(negedge clk);
        chk("brst idle", 32'(busy), 0);

        // Random stimulus against the model.
        rst = 1'b1;
        model_step();
        @(negedge clk);
        for (int i = 0; i < 5000 && n_errors < 20; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 99) < 92);
            start = ($urandom_range(0, 99) < 8);
            stop = ($urandom_range(0, 79) == 0);
            mode = 1'($urandom);
            target = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            stepSize = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
            holdTicks = 8'($urandom_range(0, 3));
            model_step();
            @(negedge clk);
            chk($sformatf("rnd%0d duty", i), 32'(dutyCycle), 32'(md));
            chk($sformatf("rnd%0d busy", i), 32'(busy), 32'(ph != 0));
            chk($sformatf("rnd%0d done", i), 32'(done), 32'(mdone));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
